// File: rtl/fsm_ring_sequencer.sv
// fsm_ring_sequencer
//   Sequences a 7-entry programmable ring (0->1->..->6->0). Each entry holds a
//   state code and a dwell count; an entry stays current for dwell+1 unheld
//   cycles. Supplies the current index/code plus step/wrap pulses downstream.
//
// Ports
//   clock, reset          : clock (posedge) and synchronous active-high reset
//   cfg_we/addr/code/dwell : table write port, accepted only while idle
//   start, stop, hold      : begin sequencing, graceful stop, freeze countdown
//   busy                   : sequencer is in RUN or DRAIN
//   idx, code              : current ring index and its table code (registered)
//   step, wrap             : 1-cycle pulses on every advance / on the 6->0 advance
//   laps                   : wraps since the last accepted start, saturating
//   wr_drop                : 1-cycle pulse when a table write is rejected
//   cfg_err                : duplicate-code error on start
//
// Build option
//   FSM_SEQ_DUP_CHECK_EN : when defined, a start is rejected (and cfg_err set)
//   if any two table codes are equal. When undefined, cfg_err is tied low and
//   start is accepted regardless of table content.
module fsm_ring_sequencer #(
  parameter int W       = 3,
  parameter int DWELL_W = 8,
  parameter int N       = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [W-1:0]       cfg_code,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  output logic               busy,
  output logic [2:0]         idx,
  output logic [W-1:0]       code,
  output logic               step,
  output logic               wrap,
  output logic [7:0]         laps,
  output logic               wr_drop,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state;
  logic [W-1:0]       tbl_code  [N];
  logic [DWELL_W-1:0] tbl_dwell [N];
  logic [DWELL_W-1:0] cnt;
  logic [2:0]         nxt_idx;
  logic               wr_ok;
  logic               start_req;
  logic               dup;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign nxt_idx   = (idx == 3'(N - 1)) ? 3'd0 : idx + 3'd1;
  assign wr_ok     = (state == IDLE) && cfg_we && (cfg_addr <= 3'(N - 1));
  // A write in the same cycle as start wins; start with stop is a no-op.
  assign start_req = (state == IDLE) && start && !stop && !cfg_we;

`ifdef FSM_SEQ_DUP_CHECK_EN
  always_comb begin
    dup = 1'b0;
    for (int a = 0; a < N; a++) begin
      for (int b = a + 1; b < N; b++) begin
        if (tbl_code[a] == tbl_code[b]) dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)          cfg_err <= 1'b0;
    else if (wr_ok)     cfg_err <= 1'b0;
    else if (start_req) cfg_err <= dup;
  end
`else
  assign dup     = 1'b0;
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      idx     <= 3'd0;
      code    <= '0;
      cnt     <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
      laps    <= 8'd0;
      wr_drop <= 1'b0;
      for (int i = 0; i < N; i++) begin
        tbl_code[i]  <= W'(i);
        tbl_dwell[i] <= '0;
      end
    end else begin
      step    <= 1'b0;
      wrap    <= 1'b0;
      wr_drop <= cfg_we && !wr_ok;

      if (wr_ok) begin
        tbl_code[cfg_addr]  <= cfg_code;
        tbl_dwell[cfg_addr] <= cfg_dwell;
        // Keep the code output coherent with the entry being shown.
        if (cfg_addr == idx) code <= cfg_code;
      end

      case (state)
        IDLE: begin
          if (start_req && !dup) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= 3'd0;
            code  <= tbl_code[0];
            cnt   <= tbl_dwell[0];
            laps  <= 8'd0;
          end
        end
        RUN: begin
          // Stop moves to DRAIN without consuming this cycle's count.
          if (stop) begin
            state <= DRAIN;
          end else if (!hold) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              idx  <= nxt_idx;
              code <= tbl_code[nxt_idx];
              cnt  <= tbl_dwell[nxt_idx];
              step <= 1'b1;
              if (idx == 3'(N - 1)) begin
                wrap <= 1'b1;
                laps <= sat_inc8(laps);
              end
            end
          end
        end
        DRAIN: begin
          // Expiry parks the ring at entry 0 instead of advancing.
          if (!hold) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              idx   <= 3'd0;
              code  <= tbl_code[0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_ring_sequencer.sv
module tb_fsm_ring_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_code;
  logic [7:0] cfg_dwell;
  logic       start;
  logic       stop;
  logic       hold;
  logic       busy;
  logic [2:0] idx;
  logic [2:0] code;
  logic       step;
  logic       wrap;
  logic [7:0] laps;
  logic       wr_drop;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are {busy, idx, code, step, wrap}.
  logic [8:0] q[$];
  logic [8:0] ex;
  wire  [8:0] obs = {busy, idx, code, step, wrap};

  fsm_ring_sequencer #(.W(3), .DWELL_W(8), .N(7)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_code(cfg_code), .cfg_dwell(cfg_dwell), .start(start), .stop(stop),
    .hold(hold), .busy(busy), .idx(idx), .code(code), .step(step),
    .wrap(wrap), .laps(laps), .wr_drop(wr_drop), .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] mk(bit b, int i, int c, bit s, bit w);
    return {b, 3'(i), 3'(c), s, w};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    cfg_we = 0; cfg_addr = 0; cfg_code = 0; cfg_dwell = 0;
    start = 0; stop = 0; hold = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic cfg_write(int a, int c, int d);
    cfg_we = 1; cfg_addr = 3'(a); cfg_code = 3'(c); cfg_dwell = 8'(d);
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({obs, laps, wr_drop, cfg_err} !== {mk(0, 0, 0, 0, 0), 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h/%0d/%b/%b exp=%h/0/0/0", obs, laps, wr_drop, cfg_err, mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_ring();
    do_reset();
    q.push_back(mk(1, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++) q.push_back(mk(1, k, k, 1, 0));
    q.push_back(mk(1, 0, 0, 1, 1));
    q.push_back(mk(1, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      stop  = (k == 8);
      tick();
      ex = q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL ring cyc=%0d got=%h exp=%h", k, obs, ex);
      end
      if (k >= 7) begin
        total++;
        if (laps !== 8'd1) begin
          bad++;
          $display("FAIL ring_laps cyc=%0d got=%0d exp=1", k, laps);
        end
      end
    end
  endtask

  task automatic test_dwell();
    do_reset();
    cfg_write(2, 5, 3);
    total++;
    if ({wr_drop, obs} !== {1'b0, mk(0, 0, 0, 0, 0)}) begin
      bad++;
      $display("FAIL dwell_write got=%b/%h exp=0/%h", wr_drop, obs, mk(0, 0, 0, 0, 0));
    end
    q.push_back(mk(1, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 1, 1, 0));
    q.push_back(mk(1, 2, 5, 1, 0));
    for (int k = 0; k < 3; k++) q.push_back(mk(1, 2, 5, 0, 0));
    q.push_back(mk(1, 3, 3, 1, 0));
    for (int k = 0; k < 7; k++) begin
      start = (k == 0);
      tick();
      ex = q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL dwell cyc=%0d got=%h exp=%h", k, obs, ex);
      end
    end
    start = 0;
    reset = 1;
    tick();
    reset = 0;
    total++;
    if ({obs, laps} !== {mk(0, 0, 0, 0, 0), 8'd0}) begin
      bad++;
      $display("FAIL reset_midrun got=%h/%0d exp=%h/0", obs, laps, mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_hold();
    do_reset();
    cfg_write(1, 1, 2);
    q.push_back(mk(1, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 1, 1, 0));
    for (int k = 2; k <= 8; k++) q.push_back(mk(1, 1, 1, 0, 0));
    q.push_back(mk(1, 2, 2, 1, 0));
    for (int k = 0; k < 10; k++) begin
      start = (k == 0);
      hold  = (k >= 3 && k <= 7);
      tick();
      ex = q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%h exp=%h", k, obs, ex);
      end
    end
    hold = 0;
  endtask

  task automatic test_stop();
    do_reset();
    cfg_write(4, 4, 2);
    q.push_back(mk(1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) q.push_back(mk(1, k, k, 1, 0));
    for (int k = 5; k <= 7; k++) q.push_back(mk(1, 4, 4, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      start = (k == 0 || k == 6);
      stop  = (k == 5 || k == 9);
      tick();
      ex = q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", k, obs, ex);
      end
    end
    start = 0; stop = 0;
    total++;
    if (laps !== 8'd0) begin
      bad++;
      $display("FAIL stop_laps got=%0d exp=0", laps);
    end
  endtask

  task automatic test_drop();
    do_reset();
    cfg_we = 1; cfg_addr = 3'd7; cfg_code = 3'd7; cfg_dwell = 8'd9;
    tick();
    cfg_we = 0;
    total++;
    if ({wr_drop, obs} !== {1'b1, mk(0, 0, 0, 0, 0)}) begin
      bad++;
      $display("FAIL drop_addr7 got=%b/%h exp=1/%h", wr_drop, obs, mk(0, 0, 0, 0, 0));
    end
    tick();
    total++;
    if (wr_drop !== 1'b0) begin
      bad++;
      $display("FAIL drop_pulse got=%b exp=0", wr_drop);
    end
    q.push_back(mk(1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) q.push_back(mk(1, k, k, 1, 0));
    for (int k = 0; k < 5; k++) begin
      start = (k == 0);
      cfg_we = (k == 1); cfg_addr = 3'd3; cfg_code = 3'd7; cfg_dwell = 8'd5;
      tick();
      ex = q.pop_front();
      total++;
      if ({wr_drop, obs} !== {(k == 1), ex}) begin
        bad++;
        $display("FAIL drop_busy cyc=%0d got=%b/%h exp=%b/%h", k, wr_drop, obs, (k == 1), ex);
      end
    end
    do_reset();
    start = 1; stop = 1;
    tick();
    tick();
    start = 0; stop = 0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_stop got=%b exp=0", busy);
    end
    start = 1; cfg_we = 1; cfg_addr = 3'd0; cfg_code = 3'd3; cfg_dwell = 8'd0;
    tick();
    cfg_we = 0;
    total++;
    if ({wr_drop, obs} !== {1'b0, mk(0, 0, 3, 0, 0)}) begin
      bad++;
      $display("FAIL start_with_write got=%b/%h exp=0/%h", wr_drop, obs, mk(0, 0, 3, 0, 0));
    end
    tick();
    start = 0;
    total++;
    if (obs !== mk(1, 0, 3, 0, 0)) begin
      bad++;
      $display("FAIL start_after_write got=%h exp=%h", obs, mk(1, 0, 3, 0, 0));
    end
  endtask

  task automatic test_laps();
    int exp_laps;
    do_reset();
    for (int k = 0; k <= 7 * 257; k++) begin
      start = (k == 0);
      tick();
      if (k % 7 == 0) begin
        exp_laps = (k / 7 > 255) ? 255 : k / 7;
        total++;
        if (laps !== 8'(exp_laps)) begin
          bad++;
          $display("FAIL laps cyc=%0d got=%0d exp=%0d", k, laps, exp_laps);
        end
      end
    end
    stop = 1;
    tick();
    stop = 0;
    tick();
    total++;
    if ({busy, laps} !== {1'b0, 8'd255}) begin
      bad++;
      $display("FAIL laps_held got=%b/%0d exp=0/255", busy, laps);
    end
    start = 1;
    tick();
    start = 0;
    total++;
    if ({busy, laps} !== {1'b1, 8'd0}) begin
      bad++;
      $display("FAIL laps_restart got=%b/%0d exp=1/0", busy, laps);
    end
  endtask

  task automatic test_dup();
    do_reset();
    cfg_write(1, 6, 0);
    cfg_write(3, 6, 0);
    start = 1;
    tick();
    start = 0;
`ifdef FSM_SEQ_DUP_CHECK_EN
    total++;
    if ({busy, cfg_err} !== 2'b01) begin
      bad++;
      $display("FAIL dup_reject got=%b%b exp=01", busy, cfg_err);
    end
    cfg_write(3, 3, 0);
    total++;
    if ({busy, cfg_err} !== 2'b00) begin
      bad++;
      $display("FAIL dup_clear got=%b%b exp=00", busy, cfg_err);
    end
    start = 1;
    tick();
    start = 0;
    total++;
    if ({busy, cfg_err} !== 2'b10) begin
      bad++;
      $display("FAIL dup_restart got=%b%b exp=10", busy, cfg_err);
    end
`else
    total++;
    if ({busy, cfg_err} !== 2'b10) begin
      bad++;
      $display("FAIL dup_ignored got=%b%b exp=10", busy, cfg_err);
    end
`endif
  endtask

  initial begin
    idle_in();
    reset = 1;
    test_reset();
    test_ring();
    test_dwell();
    test_hold();
    test_stop();
    test_drop();
    test_laps();
    test_dup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
